system_mutex_client: RTL and testbench

Hardware-side requester for the `system_mutex` peripheral. Sits directly upstream of the mutex slave as a single-master Avalon-MM client and acquires the mutex on behalf of local fabric logic (e.g. a DMA or accelerator sharing a buffer with the CPU). It uses a write-then-verify-read protocol, retries with capped exponential backoff, and holds the lock until released.

---
 rtl/system_mutex_pkg.sv | 33 +++
 rtl/system_mutex_backoff.sv | 40 ++++
 rtl/system_mutex_client.sv | 145 ++++++++++++++
 tb/tb_system_mutex_client.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/system_mutex_pkg.sv
// Shared types and register-field helpers for the system_mutex requester.
// The tag and value fields of the 32-bit mutex word are defined here once.
package system_mutex_pkg;

  typedef logic [15:0] tag_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLAIM,
    ST_CHECK,
    ST_BACKOFF,
    ST_HELD,
    ST_RELEASE,
    ST_FAIL
  } state_t;

  localparam logic MUTEX_ADDR_VALUE = 1'b0;
  localparam logic MUTEX_ADDR_RESET = 1'b1;

  localparam int OWNER_MSB = 31;
  localparam int OWNER_LSB = 16;
  localparam int VALUE_MSB = 15;
  localparam int VALUE_LSB = 0;

  function automatic logic [31:0] mutex_word(input tag_t owner, input tag_t value);
    logic [31:0] word;
    word = '0;
    word[OWNER_MSB:OWNER_LSB] = owner;
    word[VALUE_MSB:VALUE_LSB] = value;
    return word;
  endfunction

endpackage

// File: rtl/system_mutex_backoff.sv
// Capped exponential backoff timer: each start loads the current length and
// doubles it for next time, up to BACKOFF_MAX; clear returns the length to 1.
module system_mutex_backoff
  import system_mutex_pkg::*;
#(
  parameter int BACKOFF_MAX = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic start,
  output logic done
);

  // One extra bit so BACKOFF_MAX itself is representable; doubling stops there.
  localparam int W = $clog2(BACKOFF_MAX) + 1;
  localparam logic [W-1:0] LEN_ONE = W'(1);
  localparam logic [W-1:0] LEN_MAX = W'(BACKOFF_MAX);

  logic [W-1:0] len_q;
  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      len_q   <= LEN_ONE;
      count_q <= '0;
    end else if (start) begin
      count_q <= len_q;
      if (len_q < LEN_MAX) len_q <= len_q << 1;
    end else if (count_q != '0) begin
      count_q <= count_q - LEN_ONE;
    end
  end

  // High in the last waiting cycle, so the caller leaves on the same edge.
  assign done = (count_q == LEN_ONE);

endmodule

// File: rtl/system_mutex_client.sv
// Hardware requester for the system_mutex peripheral: claim by write, confirm
// by read-back, retry with capped exponential backoff, hold until released.
module system_mutex_client
  import system_mutex_pkg::*;
#(
  parameter tag_t OWNER_ID    = 16'h0002,
  parameter tag_t LOCK_VALUE  = 16'h0001,
  parameter int   BACKOFF_MAX = 64,
  parameter int   MAX_TRIES   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        acq_req,
  output logic        acq_gnt,
  output logic        acq_fail,
  input  logic        rel_req,
  output logic        rel_done,
  output logic [7:0]  attempts,
  output logic        avm_address,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  localparam logic [31:0] CLAIM_WORD   = mutex_word(OWNER_ID, LOCK_VALUE);
  localparam logic [31:0] RELEASE_WORD = mutex_word(OWNER_ID, 16'h0000);

  state_t state;
  logic   claim_ok;
  logic   last_try;
  logic   bo_clear;
  logic   bo_start;
  logic   bo_done;

  assign claim_ok = (avm_readdata == CLAIM_WORD);
  assign last_try = (MAX_TRIES != 0) && ((int'(attempts) + 1) == MAX_TRIES);
  assign bo_clear = (state == ST_IDLE);
  assign bo_start = (state == ST_CHECK) && !claim_ok;

  system_mutex_backoff #(
    .BACKOFF_MAX(BACKOFF_MAX)
  ) u_backoff (
    .clk  (clk),
    .reset(reset),
    .clear(bo_clear),
    .start(bo_start),
    .done (bo_done)
  );

  // Outputs are registered with the state: each branch drives the values
  // for the state being entered, so the bus strobes line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      acq_gnt        <= 1'b0;
      acq_fail       <= 1'b0;
      rel_done       <= 1'b0;
      attempts       <= '0;
      avm_address    <= MUTEX_ADDR_VALUE;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_writedata  <= '0;
    end else begin
      avm_address    <= MUTEX_ADDR_VALUE;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_writedata  <= '0;
      acq_fail       <= 1'b0;
      rel_done       <= 1'b0;

      case (state)
        ST_IDLE: begin
          acq_gnt  <= 1'b0;
          attempts <= '0;
          if (acq_req) begin
            state          <= ST_CLAIM;
            avm_chipselect <= 1'b1;
            avm_write      <= 1'b1;
            avm_writedata  <= CLAIM_WORD;
          end
        end

        ST_CLAIM: begin
          state          <= ST_CHECK;
          avm_chipselect <= 1'b1;
          avm_read       <= 1'b1;
        end

        ST_CHECK: begin
          if (claim_ok) begin
            state   <= ST_HELD;
            acq_gnt <= 1'b1;
          end else begin
            if (attempts != 8'hFF) attempts <= attempts + 8'd1;
            if (last_try) begin
              state    <= ST_FAIL;
              acq_fail <= 1'b1;
            end else begin
              state <= ST_BACKOFF;
            end
          end
        end

        ST_BACKOFF: begin
          if (!acq_req) begin
            state <= ST_IDLE;
          end else if (bo_done) begin
            state          <= ST_CLAIM;
            avm_chipselect <= 1'b1;
            avm_write      <= 1'b1;
            avm_writedata  <= CLAIM_WORD;
          end
        end

        ST_HELD: begin
          if (rel_req) begin
            state          <= ST_RELEASE;
            acq_gnt        <= 1'b0;
            avm_chipselect <= 1'b1;
            avm_write      <= 1'b1;
            avm_writedata  <= RELEASE_WORD;
          end
        end

        ST_RELEASE: begin
          state    <= ST_IDLE;
          rel_done <= 1'b1;
        end

        ST_FAIL: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_system_mutex_client.sv
// Directed bench for system_mutex_client: two requesters (retry-forever and
// MAX_TRIES=3), each against its own behavioural system_mutex slave.
module tb_system_mutex_client;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Requester 0: retry forever
  logic        acq_req, acq_gnt, acq_fail, rel_req, rel_done;
  logic [7:0]  attempts;
  logic        avm_address, avm_chipselect, avm_write, avm_read;
  logic [31:0] avm_writedata, avm_readdata;

  // Requester 1: gives up after three failures
  logic        acq_req1, acq_gnt1, acq_fail1, rel_req1, rel_done1;
  logic [7:0]  attempts1;
  logic        avm_address1, avm_chipselect1, avm_write1, avm_read1;
  logic [31:0] avm_writedata1, avm_readdata1;

  system_mutex_client dut (
    .clk(clk), .reset(reset),
    .acq_req(acq_req), .acq_gnt(acq_gnt), .acq_fail(acq_fail),
    .rel_req(rel_req), .rel_done(rel_done), .attempts(attempts),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
  );

  system_mutex_client #(.MAX_TRIES(3)) dut1 (
    .clk(clk), .reset(reset),
    .acq_req(acq_req1), .acq_gnt(acq_gnt1), .acq_fail(acq_fail1),
    .rel_req(rel_req1), .rel_done(rel_done1), .attempts(attempts1),
    .avm_address(avm_address1), .avm_chipselect(avm_chipselect1),
    .avm_write(avm_write1), .avm_read(avm_read1),
    .avm_writedata(avm_writedata1), .avm_readdata(avm_readdata1)
  );

  // Behavioural slaves: a write lands only if the mutex is free or owned by the writer.
  logic        slv_init, force0;
  logic [31:0] force_val0, slv0, slv1;

  always @(posedge clk) begin
    if (slv_init) slv0 <= 32'h0001_0001;
    else if (force0) slv0 <= force_val0;
    else if (avm_chipselect && avm_write && !avm_address &&
             (slv0[15:0] == 16'h0 || slv0[31:16] == avm_writedata[31:16]))
      slv0 <= avm_writedata;
  end

  always @(posedge clk) begin
    if (slv_init) slv1 <= 32'h0001_0001;
    else if (avm_chipselect1 && avm_write1 && !avm_address1 &&
             (slv1[15:0] == 16'h0 || slv1[31:16] == avm_writedata1[31:16]))
      slv1 <= avm_writedata1;
  end

  assign avm_readdata  = (avm_chipselect && avm_read && !avm_address) ? slv0 : 32'h0;
  assign avm_readdata1 = (avm_chipselect1 && avm_read1 && !avm_address1) ? slv1 : 32'h0;

  // Bus activity monitors
  int bus_cnt = 0, addr1_cnt = 0, wr_cnt1 = 0;
  always @(posedge clk) begin
    if (avm_chipselect) bus_cnt <= bus_cnt + 1;
    if ((avm_chipselect && avm_address) || (avm_chipselect1 && avm_address1))
      addr1_cnt <= addr1_cnt + 1;
    if (avm_chipselect1 && avm_write1) wr_cnt1 <= wr_cnt1 + 1;
  end

  logic [3:0] bus0;
  assign bus0 = {avm_chipselect, avm_write, avm_read, avm_address};

  localparam logic [3:0] BUS_IDLE = 4'b0000;
  localparam logic [3:0] BUS_WR   = 4'b1100;
  localparam logic [3:0] BUS_RD   = 4'b1010;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; slave force requests last one rising edge.
  task automatic step();
    @(negedge clk);
    force0 = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap;
    int len;
    int cyc;

    reset = 1'b1; acq_req = 1'b0; rel_req = 1'b0; acq_req1 = 1'b0; rel_req1 = 1'b0;
    slv_init = 1'b1; force0 = 1'b0; force_val0 = 32'h0;
    repeat (3) step();
    slv_init = 1'b0;

    // Reset values
    check("rst_flags", 32'({acq_gnt, acq_fail, rel_done, attempts}), 32'h0);
    check("rst_bus", 32'(bus0), 32'(BUS_IDLE));
    check("rst_wdata", avm_writedata, 32'h0);
    check("rst_slave", slv0, 32'h0001_0001);
    reset = 1'b0;

    // Free mutex: write at +1, read at +2, grant at +3
    force0 = 1'b1; force_val0 = 32'h0; step();
    acq_req = 1'b1; step();
    check("free_wr", 32'(bus0), 32'(BUS_WR));
    check("free_wdata", avm_writedata, 32'h0002_0001);
    step();
    check("free_rd", 32'(bus0), 32'(BUS_RD));
    step();
    check("free_gnt", 32'({acq_gnt, bus0}), 32'h10);
    check("free_att", 32'(attempts), 32'h0);
    acq_req = 1'b0; step();
    check("held_ignores_req", 32'(acq_gnt), 32'h1);

    // Release: write at +1 with grant low, rel_done at +2
    rel_req = 1'b1; step(); rel_req = 1'b0;
    check("rel_wr", 32'({acq_gnt, bus0}), 32'(BUS_WR));
    check("rel_wdata", avm_writedata, 32'h0002_0000);
    step();
    check("rel_done", 32'({rel_done, bus0}), 32'h10);
    check("rel_slave_val", 32'(slv0[15:0]), 32'h0);
    step();
    check("rel_done_pulse", 32'(rel_done), 32'h0);

    // rel_req in IDLE does nothing
    n = bus_cnt;
    rel_req = 1'b1; step(); rel_req = 1'b0;
    repeat (4) step();
    check("idle_rel_bus", 32'(bus_cnt - n), 32'h0);
    check("idle_rel_gnt", 32'(acq_gnt), 32'h0);

    // Contended: owner 1 holds it; backoff 1,2,4,..,64,64 then free after 9th failure
    force0 = 1'b1; force_val0 = 32'h0001_0001; step();
    acq_req = 1'b1; step();
    for (int k = 1; k <= 9; k++) begin
      len = (k > 7) ? 64 : (1 << (k - 1));
      check("ct_wr", 32'(bus0), 32'(BUS_WR));
      step();
      check("ct_rd", 32'(bus0), 32'(BUS_RD));
      step();
      check("ct_att", 32'(attempts), 32'(k));
      if (k == 9) begin
        force0 = 1'b1; force_val0 = 32'h0;
      end
      gap = 0;
      while (bus0 != BUS_WR && gap < 200) begin
        gap++;
        step();
      end
      check("ct_gap", 32'(gap), 32'(len));
    end
    check("ct_wr_last", 32'(bus0), 32'(BUS_WR));
    step();
    check("ct_rd_last", 32'(bus0), 32'(BUS_RD));
    step();
    check("ct_gnt", 32'(acq_gnt), 32'h1);
    check("ct_att_held", 32'(attempts), 32'd9);
    check("ct_slave", slv0, 32'h0002_0001);
    acq_req = 1'b0; rel_req = 1'b1; step(); rel_req = 1'b0;
    step(); step();

    // Drop acq_req during backoff: straight to IDLE, no more bus cycles
    force0 = 1'b1; force_val0 = 32'h0001_0001; step();
    acq_req = 1'b1; step(); step(); step();
    check("drop_in_backoff", 32'({attempts, bus0}), 32'h10);
    acq_req = 1'b0;
    n = bus_cnt;
    repeat (5) step();
    check("drop_bus", 32'(bus_cnt - n), 32'h0);
    check("drop_idle", 32'({acq_gnt, attempts}), 32'h0);

    // Reset while HELD: outputs clear, slave stays locked by us, re-acquire first try
    force0 = 1'b1; force_val0 = 32'h0; step();
    acq_req = 1'b1; repeat (3) step();
    check("pre_rst_gnt", 32'(acq_gnt), 32'h1);
    reset = 1'b1; step();
    check("rst_held_flags", 32'({acq_gnt, acq_fail, rel_done, attempts, bus0}), 32'h0);
    check("rst_held_wdata", avm_writedata, 32'h0);
    reset = 1'b0;
    check("rst_held_slave", slv0, 32'h0002_0001);
    step();
    check("reacq_wr", 32'(bus0), 32'(BUS_WR));
    step();
    check("reacq_rd", 32'(bus0), 32'(BUS_RD));
    step();
    check("reacq_gnt", 32'({acq_gnt, attempts}), 32'h100);
    acq_req = 1'b0; rel_req = 1'b1; step(); rel_req = 1'b0; step();
    check("reacq_rel_slave", slv0, 32'h0002_0000);

    // MAX_TRIES=3 against a permanently held slave: fail pulse at cycle 10
    n = wr_cnt1;
    acq_req1 = 1'b1;
    cyc = 0;
    while (!acq_fail1 && cyc < 100) begin
      step();
      cyc++;
    end
    check("mt_fail_cycle", 32'(cyc), 32'd10);
    check("mt_writes", 32'(wr_cnt1 - n), 32'd3);
    check("mt_att", 32'(attempts1), 32'd3);
    acq_req1 = 1'b0; step();
    check("mt_pulse", 32'({acq_fail1, acq_gnt1}), 32'h0);
    repeat (4) step();
    check("mt_idle_writes", 32'(wr_cnt1 - n), 32'd3);
    check("mt_slave", slv1, 32'h0001_0001);

    check("addr1_never", 32'(addr1_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
